// File: rtl/ib_div_16x8_rs.sv
// ---------------------------------------------------------------------------
// ib_div_16x8_rs
// Sequential restoring unsigned divider: 16-bit dividend / 8-bit divisor.
// One quotient bit is retired per clock. The latency is fixed: o_done pulses
// in the 17th cycle after the accepting edge. A new operation may start
// directly from DONE, giving one result every 17 cycles.
//
// Ports:
//   i_clk    clock, all state on rising edge
//   i_rst    asynchronous active-high reset
//   i_start  start request, accepted in IDLE or DONE
//   i_a      dividend, captured on the accepting edge
//   i_b      divisor, captured on the accepting edge
//   o_q      quotient (registered, holds the last result)
//   o_r      remainder (registered, holds the last result)
//   o_dz     divide-by-zero flag for the published result
//   o_busy   high while iterating (RUN)
//   o_done   one-cycle pulse when a fresh result is on o_q/o_r/o_dz
// ---------------------------------------------------------------------------
module ib_div_16x8_rs (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_q,
  output logic [7:0]  o_r,
  output logic        o_dz,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_a;     // dividend shift register, MSB feeds the partial
  logic [7:0]  r_b;     // captured divisor
  logic [7:0]  r_part;  // partial remainder between iterations
  logic [15:0] r_qs;    // quotient shift register
  logic [3:0]  r_cnt;   // iterations remaining minus one
  logic [15:0] r_q;
  logic [7:0]  r_r;
  logic        r_dz;

  logic        w_accept;
  logic        w_last;
  logic [8:0]  w_p;
  logic        w_ge;
  logic [8:0]  w_part_nxt;
  logic [15:0] w_qs_nxt;

  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == 4'd0);

  // The compare/subtract is done at 9 bits so it cannot overflow. After a
  // successful subtract the result is below the divisor, and without one
  // p[8] was already 0 (partial < divisor), so the stored partial always
  // fits in 8 bits.
  assign w_p        = {r_part, r_a[15]};
  assign w_ge       = (w_p >= {1'b0, r_b});
  assign w_part_nxt = w_ge ? (w_p - {1'b0, r_b}) : w_p;
  assign w_qs_nxt   = {r_qs[14:0], w_ge};

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy = (r_state == S_RUN);
    o_done = (r_state == S_DONE);
  end

  // Datapath: capture, iterate, and publish on the final iteration
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_part <= '0;
      r_qs   <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_part <= '0;
      r_qs   <= '0;
      r_cnt  <= 4'd15;
    end else if (r_state == S_RUN) begin
      r_a    <= {r_a[14:0], 1'b0};
      r_part <= w_part_nxt[7:0];
      r_qs   <= w_qs_nxt;
      r_cnt  <= r_cnt - 4'd1;
      if (w_last) begin
        // With a zero divisor every compare succeeds and nothing is ever
        // subtracted, so the partial ends holding dividend[7:0]; only the
        // quotient is forced explicitly.
        r_dz <= (r_b == 8'd0);
        r_q  <= (r_b == 8'd0) ? 16'hFFFF : w_qs_nxt;
        r_r  <= w_part_nxt[7:0];
      end
    end
  end

  assign o_q  = r_q;
  assign o_r  = r_r;
  assign o_dz = r_dz;

endmodule

// File: doc/ib_div_16x8_rs.md
Name: ib_div_16x8_rs

Overview:
Sequential restoring unsigned divider, 16-bit dividend by 8-bit divisor. It produces a 16-bit quotient and an 8-bit remainder. It is the inverse companion to the ib_mul 8x8 multipliers: any 16-bit product they emit can be split back into its factors. It is a start/done block, retiring one quotient bit per cycle, with a fixed and deterministic latency.

Parameters:
None. Widths are fixed: 16-bit dividend, 8-bit divisor, 16-bit quotient, 8-bit remainder.

Ports:
i_clk     input   1   clock, all state on rising edge
i_rst     input   1   asynchronous active-high reset
i_start   input   1   start request, sampled on rising edge
i_a       input   16  dividend, captured when start is accepted
i_b       input   8   divisor, captured when start is accepted
o_q       output  16  quotient
o_r       output  8   remainder
o_dz      output  1   divide-by-zero flag for the current result
o_busy    output  1   high while an operation is in progress
o_done    output  1   single-cycle pulse: result valid

Behaviour:
- Reset (i_rst=1, asynchronous):
  - state=IDLE, all registers cleared.
  - o_q=0, o_r=0, o_dz=0, o_busy=0, o_done=0.
  - Reset mid-operation aborts immediately; no o_done is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - i_start is accepted only in IDLE or DONE.
  - On the accepting edge (E0): latch dividend into the shift register, latch divisor, clear the 9-bit partial remainder, set the bit counter to 15, go to RUN.
  - i_start in RUN is ignored; the operation continues unaffected.
- RUN, one iteration per edge E1..E16:
  - p = {partial[7:0], dividend_msb}; shift the dividend register left by one.
  - If p >= {1'b0, divisor}: partial = p - divisor and quotient bit = 1.
  - Otherwise: partial = p and quotient bit = 0.
  - The quotient bit is shifted into the LSB of the quotient register.
  - Counter decrements each iteration; at E16 (counter was 0) go to DONE.
- DONE (the cycle after E16):
  - o_done=1 for exactly one cycle. o_q and o_r show the final result.
  - Next edge: to RUN if i_start=1 (back-to-back, zero idle cycles), else to IDLE.
- Latency: o_done is high in the 17th cycle after the accepting edge. Throughput is one operation per 17 cycles.
- o_busy = 1 in RUN, 0 in IDLE and DONE.
- Output hold: o_q, o_r and o_dz are registered. They hold the last result through IDLE until the next accepting edge. During RUN they hold the previous result; intermediate iteration values never appear on them.
- Divide by zero (captured divisor == 0):
  - Same state sequence and same latency as a normal operation.
  - Final result is forced to o_q=16'hFFFF, o_r=dividend[7:0], o_dz=1.
  - o_dz clears on the next accepted start with a nonzero divisor, when that result is published.
- Arithmetic:
  - Partial remainder is 9 bits, so the compare/subtract never overflows.
  - Final partial[8] is always 0 for nonzero divisors; o_r=partial[7:0] < divisor.
  - Invariant for nonzero divisor: o_q*divisor + o_r == dividend.
- Input handling: i_a and i_b are don't-care outside the accepting edge. Changes during RUN have no effect.

Test Plan:
- Reset then idle -> o_q=0, o_r=0, o_dz=0, o_busy=0, o_done=0; no o_done with i_start held low for 50 cycles.
- i_a=16'h03E8 (1000), i_b=8'h07, one-cycle start -> o_busy high for 16 cycles; o_done in the 17th cycle with o_q=16'h008E (142), o_r=8'h06, o_dz=0.
- Corner values:
  - i_a=16'hFFFF, i_b=8'hFF -> o_q=16'h0101, o_r=0.
  - i_a=16'hFFFF, i_b=8'h01 -> o_q=16'hFFFF, o_r=0.
  - i_a=16'h0005, i_b=8'h0A -> o_q=0, o_r=8'h05.
- i_a=16'h1234, i_b=0 -> o_done after 17 cycles with o_q=16'hFFFF, o_r=8'h34, o_dz=1. A following 0x0064/0x0A -> o_q=0x000A, o_r=0, o_dz=0.
- i_start held high continuously, with new operands presented on each DONE cycle -> o_done every 17 cycles; i_start pulses during RUN ignored; o_q/o_r unchanged during RUN.
- i_rst asserted at iteration 8, then released and a fresh start 0x00FF/0x10 -> no done for the aborted operation; result o_q=0x000F, o_r=0x0F.
- Randomized: 10k random pairs with nonzero divisor -> o_q*i_b + o_r == i_a and o_r < i_b.
